reg_load_sequencer: RTL

Bus-side writer for the 8-bit breadboard-style register's load interface. Accepts bytes from an upstream valid/ready source and buffers them in a small FIFO. Each byte is presented on the data bus with setup and hold windows around a single-cycle active-low load strobe. Also issues single-cycle register clear pulses on request. Sits between control logic and one or more load-strobed registers sharing the bus.

---
 rtl/reg_load_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/reg_load_sequencer.sv
// Bus-side writer for a load-strobed register: FIFO-buffered bytes presented on DOUT with
// setup/hold windows around a single-cycle active-low LOADn, plus on-demand clear pulses.
module reg_load_sequencer #(
   parameter int unsigned DEPTH     = 4,
   parameter int unsigned SETUP_CYC = 1,
   parameter int unsigned HOLD_CYC  = 1
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic [7:0]               WR_DATA,
   input  logic                     WR_VALID,
   output logic                     WR_READY,
   input  logic                     CLR_REQ,
   output logic [7:0]               DOUT,
   output logic                     LOADn,
   output logic                     CLR,
   output logic                     BUSY,
   output logic [$clog2(DEPTH):0]   LEVEL
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned LW = PW + 1;
   localparam logic [LW-1:0] DepthL = LW'(DEPTH);
   localparam int unsigned SetupLastI = (SETUP_CYC > 0) ? SETUP_CYC - 1 : 0;
   localparam int unsigned HoldLastI  = (HOLD_CYC > 0) ? HOLD_CYC - 1 : 0;
   localparam logic [2:0] SetupLast = SetupLastI[2:0];
   localparam logic [2:0] HoldLast  = HoldLastI[2:0];

   typedef enum logic [2:0] {StIdle, StClear, StSetup, StStrobe, StHold} state_e;

   state_e          state_q, state_d;
   logic [2:0]      cnt_q, cnt_d;
   logic [7:0]      mem_q [DEPTH];
   logic [7:0]      mem_d [DEPTH];
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]   level_q, level_d;
   logic            clr_pend_q, clr_pend_d;
   logic [7:0]      dout_q, dout_d;
   logic            loadn_q, loadn_d;
   logic            clr_q, clr_d;
   logic            push, pop, clr_enter;

   // Readiness depends only on registered occupancy, never on WR_VALID.
   assign WR_READY = (level_q != DepthL);
   assign push     = WR_VALID & WR_READY;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      pop       = 1'b0;
      clr_enter = 1'b0;
      case (state_q)
         StIdle: begin
            if (clr_pend_q) begin
               clr_enter = 1'b1;
               state_d   = StClear;
            end else if (level_q != '0) begin
               pop     = 1'b1;
               cnt_d   = '0;
               state_d = (SETUP_CYC == 0) ? StStrobe : StSetup;
            end
         end
         StClear: state_d = StIdle;
         StSetup: begin
            if (cnt_q == SetupLast) state_d = StStrobe;
            else                    cnt_d   = cnt_q + 3'd1;
         end
         StStrobe: begin
            cnt_d   = '0;
            state_d = (HOLD_CYC == 0) ? StIdle : StHold;
         end
         StHold: begin
            if (cnt_q == HoldLast) state_d = StIdle;
            else                   cnt_d   = cnt_q + 3'd1;
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      dout_d   = dout_q;
      if (push) begin
         mem_d[wr_ptr_q] = WR_DATA;
         wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (pop) begin
         dout_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + 1'b1;
      end
      if (push && !pop)      level_d = level_q + 1'b1;
      else if (pop && !push) level_d = level_q - 1'b1;
      // A request landing on the service edge is kept for a later pulse.
      clr_pend_d = CLR_REQ | (clr_pend_q & ~clr_enter);
      loadn_d    = (state_d != StStrobe);
      clr_d      = (state_d == StClear);
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         level_q    <= '0;
         clr_pend_q <= 1'b0;
         dout_q     <= 8'h00;
         loadn_q    <= 1'b1;
         clr_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         level_q    <= level_d;
         clr_pend_q <= clr_pend_d;
         dout_q     <= dout_d;
         loadn_q    <= loadn_d;
         clr_q      <= clr_d;
      end
   end

   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign DOUT  = dout_q;
   assign LOADn = loadn_q;
   assign CLR   = clr_q;
   assign LEVEL = level_q;
   assign BUSY  = (level_q != '0) | clr_pend_q | (state_q != StIdle);

endmodule
